// File: rtl/sr_flip_flop_if.sv
// Set/reset request and state bundle for a bank of WIDTH SR flip-flops.
// master drives S/R and observes the state; slave is the flip-flop bank.
interface sr_flip_flop_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic [WIDTH-1:0] ILLEGAL;

  modport master (
    output S,
    output R,
    input  Q,
    input  Q_bar,
    input  ILLEGAL
  );

  modport slave (
    input  S,
    input  R,
    output Q,
    output Q_bar,
    output ILLEGAL
  );
endinterface

// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent rising-edge SR flip-flops with synchronous reset,
// complementary outputs, a configurable S=R=1 policy and a registered S=R=1 flag.
module sr_flip_flop #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter int                   BOTH_MODE   = 0
) (
  input  logic                CLK,
  input  logic                RST,
  sr_flip_flop_if.slave       sr
);

  typedef enum logic [1:0] {
    BOTH_HOLD   = 2'd0,
    BOTH_SET    = 2'd1,
    BOTH_RESET  = 2'd2,
    BOTH_TOGGLE = 2'd3
  } both_e;

  // Out-of-range policy values collapse to hold.
  localparam both_e BOTH_ACT = (BOTH_MODE >= 0 && BOTH_MODE <= 3)
                             ? both_e'(BOTH_MODE[1:0]) : BOTH_HOLD;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] illegal_q;
  logic [WIDTH-1:0] illegal_d;

  always_comb begin
    q_d       = q_q;
    illegal_d = sr.S & sr.R;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case ({sr.S[i], sr.R[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11: begin
          case (BOTH_ACT)
            BOTH_SET:    q_d[i] = 1'b1;
            BOTH_RESET:  q_d[i] = 1'b0;
            BOTH_TOGGLE: q_d[i] = ~q_q[i];
            default:     q_d[i] = q_q[i];
          endcase
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q       <= RESET_VALUE;
      illegal_q <= '0;
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
    end
  end

  // Q_bar is derived from the same flops, so Q and Q_bar can never be equal.
  assign sr.Q       = q_q;
  assign sr.Q_bar   = ~q_q;
  assign sr.ILLEGAL = illegal_q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Self-checking bench for sr_flip_flop: policy sweep, wide bank, random stimulus
// against a behavioural model, and a four-bit SR counter built from single bits.
module tb_sr_flip_flop;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Five single-bit flops: BOTH_MODE 0,1,2,3 and an out-of-range 7 (index 4).
  logic [4:0] m_s, m_r, m_q, m_qb, m_ill;

  for (genvar g = 0; g < 5; g++) begin : g_modes
    sr_flip_flop_if #(.WIDTH(1)) u_if ();
    assign u_if.S   = m_s[g];
    assign u_if.R   = m_r[g];
    assign m_q[g]   = u_if.Q;
    assign m_qb[g]  = u_if.Q_bar;
    assign m_ill[g] = u_if.ILLEGAL;
    sr_flip_flop #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0),
      .BOTH_MODE   ((g == 4) ? 7 : g)
    ) u_dut (
      .CLK (CLK),
      .RST (RST),
      .sr  (u_if)
    );
  end

  // Four-bit bank with non-zero reset value and toggle policy.
  sr_flip_flop_if #(.WIDTH(4)) w_if ();
  sr_flip_flop #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010),
    .BOTH_MODE   (3)
  ) u_w4 (
    .CLK (CLK),
    .RST (RST),
    .sr  (w_if)
  );

  // Counter: c_q = {Qa, Qb, Qc, Qd}.
  logic [3:0] c_q, c_qb, c_ill, c_s, c_r;
  logic       ca, cb, cc, cd;
  assign {ca, cb, cc, cd} = c_q;
  assign c_s = {cb & ~cc & ~cd, ~ca & cc & ~cd, cd & (ca ~^ cb), (ca ~^ cb) ^ cc};
  assign c_r = {~cb & ~cc & ~cd, ca & cc & ~cd, cd & (ca ^ cb), ca ^ cb ^ cc};

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    sr_flip_flop_if #(.WIDTH(1)) u_if ();
    assign u_if.S   = c_s[g];
    assign u_if.R   = c_r[g];
    assign c_q[g]   = u_if.Q;
    assign c_qb[g]  = u_if.Q_bar;
    assign c_ill[g] = u_if.ILLEGAL;
    sr_flip_flop #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0),
      .BOTH_MODE   (0)
    ) u_dut (
      .CLK (CLK),
      .RST (RST),
      .sr  (u_if)
    );
  end

  // Behavioural SR rule applied bit by bit from the truth table.
  function automatic logic [3:0] sr_ref(input logic [3:0] q, input logic [3:0] s,
                                        input logic [3:0] r, input int mode,
                                        input int unsigned w);
    logic [3:0] n;
    n = q;
    for (int unsigned i = 0; i < w; i++) begin
      if (s[i] && !r[i])       n[i] = 1'b1;
      else if (!s[i] && r[i])  n[i] = 1'b0;
      else if (s[i] && r[i]) begin
        if (mode == 1)         n[i] = 1'b1;
        else if (mode == 2)    n[i] = 1'b0;
        else if (mode == 3)    n[i] = !q[i];
      end
    end
    return n;
  endfunction

  function automatic int mode_of(input int g);
    return (g == 4) ? 7 : g;
  endfunction

  // Golden counter step: set/clear masks from the counter equations.
  function automatic logic [3:0] cnt_next(input logic [3:0] q);
    int a, b, c, d;
    logic [3:0] set, clr;
    a = int'(q[3]); b = int'(q[2]); c = int'(q[1]); d = int'(q[0]);
    set[3] = (b == 1 && c == 0 && d == 0);
    clr[3] = (b == 0 && c == 0 && d == 0);
    set[2] = (a == 0 && c == 1 && d == 0);
    clr[2] = (a == 1 && c == 1 && d == 0);
    set[1] = (d == 1 && a == b);
    clr[1] = (d == 1 && a != b);
    set[0] = (((a + b + c) % 2) == 0);
    clr[0] = (((a + b + c) % 2) == 1);
    return (q & ~clr) | set;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    m_s = '1; m_r = '0;
    w_if.S = 4'b1111; w_if.R = 4'b1111;
    tick();
    checks++;
    if ({m_q, m_qb, m_ill} !== {5'b00000, 5'b11111, 5'b00000}) begin
      failures++;
      $display("FAIL reset_w1: Q/Qb/ILL got %b/%b/%b expected 00000/11111/00000", m_q, m_qb, m_ill);
    end
    checks++;
    if ({w_if.Q, w_if.Q_bar, w_if.ILLEGAL} !== {4'b1010, 4'b0101, 4'b0000}) begin
      failures++;
      $display("FAIL reset_w4: Q/Qb/ILL got %b/%b/%b expected 1010/0101/0000", w_if.Q, w_if.Q_bar, w_if.ILLEGAL);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] sr_seq [4];
    logic       exp_seq [4];
    sr_seq  = '{2'b10, 2'b00, 2'b01, 2'b00};
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_s = {5{sr_seq[k][1]}};
      m_r = {5{sr_seq[k][0]}};
      tick();
      checks++;
      if ({m_q, m_qb} !== {{5{exp_seq[k]}}, {5{~exp_seq[k]}}}) begin
        failures++;
        $display("FAIL seq_step%0d: Q/Qb got %b/%b expected %b/%b", k, m_q, m_qb, {5{exp_seq[k]}}, {5{~exp_seq[k]}});
      end
    end
    // A set pulse entirely between edges must not reach Q.
    m_s = '1;
    #2;
    m_s = '0;
    #1;
    checks++;
    if (m_q !== 5'b00000) begin
      failures++;
      $display("FAIL mid_cycle_set: Q got %b expected 00000", m_q);
    end
    tick();
    checks++;
    if (m_q !== 5'b00000) begin
      failures++;
      $display("FAIL glitch_hold: Q got %b expected 00000", m_q);
    end
  endtask

  task automatic test_both_mode();
    m_s = '1; m_r = '0;
    tick();
    m_s = '1; m_r = '1;
    tick();
    checks++;
    if ({m_q, m_qb, m_ill} !== {5'b10011, 5'b01100, 5'b11111}) begin
      failures++;
      $display("FAIL both_first: Q/Qb/ILL got %b/%b/%b expected 10011/01100/11111", m_q, m_qb, m_ill);
    end
    tick();
    checks++;
    if ({m_q, m_qb, m_ill} !== {5'b11011, 5'b00100, 5'b11111}) begin
      failures++;
      $display("FAIL both_second: Q/Qb/ILL got %b/%b/%b expected 11011/00100/11111", m_q, m_qb, m_ill);
    end
    m_s = '0; m_r = '0;
    tick();
    checks++;
    if ({m_q, m_ill} !== {5'b11011, 5'b00000}) begin
      failures++;
      $display("FAIL both_clear: Q/ILL got %b/%b expected 11011/00000", m_q, m_ill);
    end
  endtask

  task automatic test_width4();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    w_if.S = 4'b0001; w_if.R = 4'b1000;
    tick();
    checks++;
    if ({w_if.Q, w_if.Q_bar, w_if.ILLEGAL} !== {4'b0011, 4'b1100, 4'b0000}) begin
      failures++;
      $display("FAIL w4_setreset: Q/Qb/ILL got %b/%b/%b expected 0011/1100/0000", w_if.Q, w_if.Q_bar, w_if.ILLEGAL);
    end
    w_if.S = 4'b0110; w_if.R = 4'b0110;
    tick();
    checks++;
    if ({w_if.Q, w_if.Q_bar, w_if.ILLEGAL} !== {4'b0101, 4'b1010, 4'b0110}) begin
      failures++;
      $display("FAIL w4_toggle: Q/Qb/ILL got %b/%b/%b expected 0101/1010/0110", w_if.Q, w_if.Q_bar, w_if.ILLEGAL);
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_m, exp_mi;
    logic [3:0] exp_w, exp_wi, t;
    RST = 1'b1;
    tick();
    exp_m = '0; exp_w = 4'b1010;
    for (int n = 0; n < 300; n++) begin
      RST    = ($urandom_range(0, 19) == 0);
      m_s    = 5'($urandom);
      m_r    = 5'($urandom);
      w_if.S = 4'($urandom);
      w_if.R = 4'($urandom);
      if (RST) begin
        exp_m = '0; exp_mi = '0; exp_w = 4'b1010; exp_wi = '0;
      end else begin
        for (int g = 0; g < 5; g++) begin
          t = sr_ref({3'b000, exp_m[g]}, {3'b000, m_s[g]}, {3'b000, m_r[g]}, mode_of(g), 1);
          exp_m[g] = t[0];
        end
        exp_mi = m_s & m_r;
        exp_w  = sr_ref(exp_w, w_if.S, w_if.R, 3, 4);
        exp_wi = w_if.S & w_if.R;
      end
      tick();
      checks++;
      if ({m_q, m_qb, m_ill} !== {exp_m, ~exp_m, exp_mi}) begin
        failures++;
        $display("FAIL rand_w1[%0d]: Q/Qb/ILL got %b/%b/%b expected %b/%b/%b", n, m_q, m_qb, m_ill, exp_m, ~exp_m, exp_mi);
      end
      checks++;
      if ({w_if.Q, w_if.Q_bar, w_if.ILLEGAL} !== {exp_w, ~exp_w, exp_wi}) begin
        failures++;
        $display("FAIL rand_w4[%0d]: Q/Qb/ILL got %b/%b/%b expected %b/%b/%b", n, w_if.Q, w_if.Q_bar, w_if.ILLEGAL, exp_w, ~exp_w, exp_wi);
      end
    end
    RST = 1'b0;
  endtask

  task automatic run_counter(input int steps, inout logic [3:0] exp, input string tag);
    for (int k = 0; k < steps; k++) begin
      exp = cnt_next(exp);
      tick();
      checks++;
      if ({c_q, c_qb, c_ill} !== {exp, ~exp, 4'b0000}) begin
        failures++;
        $display("FAIL %s[%0d]: Q/Qb/ILL got %b/%b/%b expected %b/%b/0000", tag, k, c_q, c_qb, c_ill, exp, ~exp);
      end
    end
  endtask

  task automatic test_counter();
    logic [3:0] exp;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp = 4'b0000;
    checks++;
    if ({c_q, c_qb} !== {4'b0000, 4'b1111}) begin
      failures++;
      $display("FAIL cnt_reset: Q/Qb got %b/%b expected 0000/1111", c_q, c_qb);
    end
    run_counter(16, exp, "cnt_run");
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp;
    exp = c_q;
    run_counter(5, exp, "cnt_pre");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp = 4'b0000;
    checks++;
    if ({c_q, c_qb, c_ill} !== {4'b0000, 4'b1111, 4'b0000}) begin
      failures++;
      $display("FAIL cnt_mid_reset: Q/Qb/ILL got %b/%b/%b expected 0000/1111/0000", c_q, c_qb, c_ill);
    end
    run_counter(6, exp, "cnt_restart");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    RST = 1'b1;
    m_s = '0; m_r = '0;
    w_if.S = '0; w_if.R = '0;
    test_reset();
    test_sequence();
    test_both_mode();
    test_width4();
    test_random();
    test_counter();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
